rgb_sequencer: RTL and testbench
================================

RGB_SEQUENCER -- requirements
Module: rgb_sequencer

Interface
REQ-001 SHALL have parameter DWELL_CYCLES, default 2_000_000, meaning CLK cycles spent in each colour state while running (legal range >= 2).
REQ-002 SHALL have parameter PWM_BITS, default 8, meaning the width of the PWM counter and of BRIGHT.
REQ-003 SHALL have port CLK  input  1  system clock; all state changes on its rising edge.
REQ-004 SHALL have port RST  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port EN  input  1  when 1, auto-advance by dwell counter; when 0, colour holds.
REQ-006 SHALL have port STEP  input  1  single-cycle request to advance one colour immediately.
REQ-007 SHALL have port BRIGHT  input  PWM_BITS  brightness duty value.
REQ-008 SHALL have port RGB_R  output  1  red drive, active-low.
REQ-009 SHALL have port RGB_G  output  1  green drive, active-low.
REQ-010 SHALL have port RGB_B  output  1  blue drive, active-low.
REQ-011 SHALL have port LED  output  1  heartbeat; toggles once per full colour cycle.
REQ-012 SHALL have port STATE  output  3  current colour state encoding.
REQ-013 SHALL have port WRAP  output  1  one-cycle pulse on MAGENTA->RED transition.

Function
REQ-014 SHALL implement an FSM with states RED=0, YELLOW=1, GREEN=2, CYAN=3, BLUE=4, MAGENTA=5, advancing in that order; MAGENTA advances to RED.
REQ-015 SHALL treat STATE values 6 and 7 as illegal and go to RED on the next edge regardless of advance events, without asserting WRAP or toggling LED.
REQ-016 SHALL keep a dwell counter, width ceil(log2(DWELL_CYCLES)), incrementing by 1 each cycle while EN=1.
REQ-017 SHALL define advance event = STEP | (EN & dwell_cnt == DWELL_CYCLES-1).
REQ-018 SHALL, on an advance event, move to the next state and clear dwell_cnt to 0 on the same edge.
REQ-019 SHALL, when STEP and dwell terminal count coincide, advance exactly one state (no double step).
REQ-020 SHALL hold dwell_cnt and state while EN=0 and STEP=0.
REQ-021 SHALL map state to colour mask {R,G,B}: RED=100, YELLOW=110, GREEN=010, CYAN=011, BLUE=001, MAGENTA=101.
REQ-022 SHALL run a free PWM counter 0..2^PWM_BITS-1 incrementing every cycle and wrapping to 0.
REQ-023 SHALL capture BRIGHT into bright_q only on the cycle pwm_cnt == 2^PWM_BITS-1, so changes apply at the next PWM period boundary.
REQ-024 SHALL compute pwm_on = (pwm_cnt < bright_q); BRIGHT=0 gives 0% duty, BRIGHT=255 gives 255/256 duty.
REQ-025 SHALL register RGB outputs: RGB_x = ~(mask_x & pwm_on), with one cycle latency from pwm_cnt/state to pin.
REQ-026 SHALL, on the MAGENTA->RED advance, toggle LED and assert WRAP for exactly that one following cycle.
REQ-027 SHALL drive STATE directly from the state register (zero latency).

Reset
REQ-028 SHALL, while RST=1, asynchronously force state=RED, dwell_cnt=0, pwm_cnt=0, bright_q=0, RGB_R=RGB_G=RGB_B=1 (off), LED=0, WRAP=0.
REQ-029 SHALL, on RST asserted mid-dwell or mid-PWM period, discard all progress; after release the first dwell lasts a full DWELL_CYCLES and the first period uses bright_q=0 (LEDs dark for the first 2^PWM_BITS cycles).

Verification (DWELL_CYCLES=4, PWM_BITS=8)
REQ-030 SHALL verify reset: RST pulse mid-run -> STATE=0, RGB=111, LED=0, WRAP=0 immediately, before any CLK edge.
REQ-031 SHALL verify auto-advance: EN=1, STEP=0 -> STATE steps 0,1,2,3,4,5,0 every 4 cycles; WRAP high one cycle after the 5->0 edge, LED toggles 0->1, second cycle LED 1->0.
REQ-032 SHALL verify hold/step: EN=0, STEP pulsed 3 times -> STATE=3, no change between pulses; STEP coinciding with terminal count under EN=1 -> advance by exactly 1, dwell_cnt=0.
REQ-033 SHALL verify PWM: state GREEN, BRIGHT=64 -> after period boundary, RGB_G low for 64 of every 256 cycles, RGB_R=RGB_B=1 throughout; BRIGHT=0 -> RGB_G constantly 1.
REQ-034 SHALL verify BRIGHT change mid-period (128->32 at pwm_cnt=10) -> current period keeps 128-cycle duty, next period 32.
REQ-035 SHALL verify colour masks: in MAGENTA with BRIGHT=255 -> RGB_R and RGB_B low 255 of 256 cycles, RGB_G constantly 1.

Source files
------------

// File: rtl/rgb_sequencer.sv
// rgb_sequencer
//   Steps an RGB LED through six colours (RED, YELLOW, GREEN, CYAN, BLUE,
//   MAGENTA). The sequence advances automatically after DWELL_CYCLES clocks
//   while EN is high, or immediately on a STEP pulse. Brightness is set by a
//   PWM whose duty value is re-sampled only at period boundaries, so the
//   output never shows a partial period.
//
// Ports
//   CLK     in   system clock, rising edge
//   RST     in   asynchronous active-high reset
//   EN      in   1 = auto-advance on dwell expiry, 0 = hold colour
//   STEP    in   single-cycle request to advance one colour now
//   BRIGHT  in   [PWM_BITS] brightness duty value
//   RGB_R   out  red drive, active-low (registered)
//   RGB_G   out  green drive, active-low (registered)
//   RGB_B   out  blue drive, active-low (registered)
//   LED     out  heartbeat, toggles on every MAGENTA->RED advance
//   STATE   out  [3] current colour state (FSM state register, no latency)
//   WRAP    out  one-cycle pulse following the MAGENTA->RED advance
//
// Control semantics: there is no valid/ready handshake. STEP is sampled on
// every rising edge and each high cycle is one advance request; EN is a level.
// A STEP that lands on the dwell terminal count is a single advance.

module rgb_sequencer #(
  parameter int DWELL_CYCLES = 2_000_000,
  parameter int PWM_BITS     = 8
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                EN,
  input  logic                STEP,
  input  logic [PWM_BITS-1:0] BRIGHT,
  output logic                RGB_R,
  output logic                RGB_G,
  output logic                RGB_B,
  output logic                LED,
  output logic [2:0]          STATE,
  output logic                WRAP
);

  localparam int                DW         = $clog2(DWELL_CYCLES);
  localparam logic [DW-1:0]     DWELL_LAST = DW'(DWELL_CYCLES - 1);
  localparam logic [PWM_BITS-1:0] PWM_LAST = '1;

  typedef enum logic [2:0] {
    RED     = 3'd0,
    YELLOW  = 3'd1,
    GREEN   = 3'd2,
    CYAN    = 3'd3,
    BLUE    = 3'd4,
    MAGENTA = 3'd5
  } state_e;

  state_e                state_q;
  state_e                state_d;
  logic [DW-1:0]         dwell_q;
  logic [PWM_BITS-1:0]   pwm_cnt_q;
  logic [PWM_BITS-1:0]   bright_q;
  logic [2:0]            rgb_q;
  logic                  led_q;
  logic                  wrap_q;

  logic                  advance;
  logic                  wrap_d;
  logic [2:0]            mask;
  logic                  pwm_on;

  // STEP and terminal count are OR-ed, so a coincidence is one advance.
  assign advance = STEP | (EN & (dwell_q == DWELL_LAST));
  assign pwm_on  = (pwm_cnt_q < bright_q);

  // State register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= RED;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, colour mask {R,G,B} and wrap detection
  always_comb begin
    state_d = state_q;
    wrap_d  = 1'b0;
    mask    = 3'b000;
    case (state_q)
      RED: begin
        mask = 3'b100;
        if (advance) state_d = YELLOW;
      end
      YELLOW: begin
        mask = 3'b110;
        if (advance) state_d = GREEN;
      end
      GREEN: begin
        mask = 3'b010;
        if (advance) state_d = CYAN;
      end
      CYAN: begin
        mask = 3'b011;
        if (advance) state_d = BLUE;
      end
      BLUE: begin
        mask = 3'b001;
        if (advance) state_d = MAGENTA;
      end
      MAGENTA: begin
        mask = 3'b101;
        if (advance) begin
          state_d = RED;
          wrap_d  = 1'b1;
        end
      end
      // Encodings 6 and 7 recover to RED unconditionally and are not a wrap.
      default: begin
        state_d = RED;
      end
    endcase
  end

  // Dwell counter: cleared on any advance, frozen while EN is low.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      dwell_q <= '0;
    end else if (advance) begin
      dwell_q <= '0;
    end else if (EN) begin
      dwell_q <= dwell_q + DW'(1);
    end
  end

  // Heartbeat and wrap pulse
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      led_q  <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      wrap_q <= wrap_d;
      led_q  <= led_q ^ wrap_d;
    end
  end

  // Free-running PWM; duty is latched on the last count of each period so a
  // BRIGHT change only takes effect from the next period.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pwm_cnt_q <= '0;
      bright_q  <= '0;
    end else begin
      pwm_cnt_q <= pwm_cnt_q + PWM_BITS'(1);
      if (pwm_cnt_q == PWM_LAST) begin
        bright_q <= BRIGHT;
      end
    end
  end

  // Registered active-low drives; reset leaves all colours dark.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rgb_q <= 3'b111;
    end else begin
      rgb_q <= ~(mask & {3{pwm_on}});
    end
  end

  assign RGB_R = rgb_q[2];
  assign RGB_G = rgb_q[1];
  assign RGB_B = rgb_q[0];
  assign LED   = led_q;
  assign WRAP  = wrap_q;
  assign STATE = state_q;

endmodule

// File: tb/tb_rgb_sequencer.sv
// tb_rgb_sequencer
//   Bench for rgb_sequencer with DWELL_CYCLES=4, PWM_BITS=8.
//   Observations are packed as {STATE[2:0], RGB_R, RGB_G, RGB_B, LED, WRAP}.

module tb_rgb_sequencer;

  localparam int DWELL = 4;
  localparam int PB    = 8;

  logic          CLK;
  logic          RST;
  logic          EN;
  logic          STEP;
  logic [PB-1:0] BRIGHT;
  logic          RGB_R;
  logic          RGB_G;
  logic          RGB_B;
  logic          LED;
  logic [2:0]    STATE;
  logic          WRAP;

  rgb_sequencer #(
    .DWELL_CYCLES(DWELL),
    .PWM_BITS    (PB)
  ) dut (
    .CLK   (CLK),
    .RST   (RST),
    .EN    (EN),
    .STEP  (STEP),
    .BRIGHT(BRIGHT),
    .RGB_R (RGB_R),
    .RGB_G (RGB_G),
    .RGB_B (RGB_B),
    .LED   (LED),
    .STATE (STATE),
    .WRAP  (WRAP)
  );

  // ---------------------------------------------------------------- clock
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // ----------------------------------------------------------- scoreboard
  logic [7:0] exp_q[$];
  int         n_checks;
  int         n_fail;

  typedef struct {
    logic       en;
    logic       step;
    logic [2:0] st;
    logic       led;
    logic       wrap;
  } vec_t;

  localparam int NVEC = 72;
  vec_t vecs[NVEC];

  function automatic logic [7:0] obs();
    return {STATE, RGB_R, RGB_G, RGB_B, LED, WRAP};
  endfunction

  function automatic vec_t mk(input logic en, input logic step, input logic [2:0] st,
                              input logic led, input logic wrap);
    vec_t v;
    v.en   = en;
    v.step = step;
    v.st   = st;
    v.led  = led;
    v.wrap = wrap;
    return v;
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string name);
    logic [7:0] got;
    logic [7:0] exp;
    got = obs();
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s: got %b but no expected value queued", name, got);
    end else begin
      exp = exp_q.pop_front();
      if (got !== exp) begin
        n_fail++;
        $display("FAIL %s: got {st,rgb,led,wrap}=%b expected %b", name, got, exp);
      end
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Runs PWM counts k_from..k_to of one period. duty is the bright value in
  // force for this period; the first nsteps ticks carry a STEP pulse; BRIGHT
  // is rewritten to chg_val just before count chg_k. Returns the number of
  // ticks in which any channel of mask was driven low.
  task automatic pwm_ticks(input string name, input int k_from, input int k_to,
                           input int duty, input logic [2:0] mask,
                           input int st0, input int nsteps,
                           input int chg_k, input logic [PB-1:0] chg_val,
                           output int lows);
    int         i;
    int         st;
    logic [2:0] exp_rgb;
    logic [7:0] got;
    lows = 0;
    for (int k = k_from; k <= k_to; k++) begin
      i = k - k_from;
      if (k == chg_k) BRIGHT = chg_val;
      STEP = (i < nsteps);
      st = st0 + ((i + 1 < nsteps) ? i + 1 : nsteps);
      exp_rgb = ~(mask & {3{k < duty}});
      exp_q.push_back({3'(st), exp_rgb, 2'b00});
      tick();
      got = obs();
      if (|(~got[4:2] & mask)) lows++;
      check(name);
    end
    STEP = 1'b0;
  endtask

  // ------------------------------------------------------------ stimulus
  initial begin
    int lows;
    n_checks = 0;
    n_fail   = 0;
    RST    = 1'b1;
    EN     = 1'b0;
    STEP   = 1'b0;
    BRIGHT = '0;

    // Auto-advance: one colour every 4 cycles, wrap and LED toggle every 24.
    for (int t = 1; t <= 48; t++) begin
      vecs[t-1] = mk(1'b1, 1'b0, 3'((t / 4) % 6), 1'((t / 24) % 2), (t % 24) == 0);
    end
    // Hold, STEP pulses, STEP on terminal count, STEP from MAGENTA, dwell hold.
    vecs[48] = mk(0, 1, 3'd1, 0, 0);
    vecs[49] = mk(0, 0, 3'd1, 0, 0);
    vecs[50] = mk(0, 0, 3'd1, 0, 0);
    vecs[51] = mk(0, 1, 3'd2, 0, 0);
    vecs[52] = mk(0, 0, 3'd2, 0, 0);
    vecs[53] = mk(0, 1, 3'd3, 0, 0);
    vecs[54] = mk(0, 0, 3'd3, 0, 0);
    vecs[55] = mk(0, 0, 3'd3, 0, 0);
    vecs[56] = mk(1, 0, 3'd3, 0, 0);
    vecs[57] = mk(1, 0, 3'd3, 0, 0);
    vecs[58] = mk(1, 0, 3'd3, 0, 0);
    vecs[59] = mk(1, 1, 3'd4, 0, 0);
    vecs[60] = mk(1, 0, 3'd4, 0, 0);
    vecs[61] = mk(1, 0, 3'd4, 0, 0);
    vecs[62] = mk(1, 0, 3'd4, 0, 0);
    vecs[63] = mk(1, 0, 3'd5, 0, 0);
    vecs[64] = mk(0, 1, 3'd0, 1, 1);
    vecs[65] = mk(0, 0, 3'd0, 1, 0);
    vecs[66] = mk(1, 0, 3'd0, 1, 0);
    vecs[67] = mk(1, 0, 3'd0, 1, 0);
    vecs[68] = mk(0, 0, 3'd0, 1, 0);
    vecs[69] = mk(0, 0, 3'd0, 1, 0);
    vecs[70] = mk(1, 0, 3'd0, 1, 0);
    vecs[71] = mk(1, 0, 3'd1, 1, 0);

    // Reset state before any clock edge
    #1;
    exp_q.push_back({3'd0, 3'b111, 2'b00});
    check("reset_initial");
    tick();
    tick();
    RST = 1'b0;

    // Table-driven FSM sequence (BRIGHT=0 keeps all drives dark)
    for (int v = 0; v < NVEC; v++) begin
      EN   = vecs[v].en;
      STEP = vecs[v].step;
      exp_q.push_back({vecs[v].st, 3'b111, vecs[v].led, vecs[v].wrap});
      tick();
      check($sformatf("fsm_vec_%0d", v));
    end
    EN   = 1'b0;
    STEP = 1'b0;

    // Asynchronous reset mid-run, observed before the next clock edge
    #2;
    RST = 1'b1;
    #1;
    exp_q.push_back({3'd0, 3'b111, 2'b00});
    check("reset_async_mid_run");
    tick();
    exp_q.push_back({3'd0, 3'b111, 2'b00});
    check("reset_held");
    RST = 1'b0;

    // P0: first period dark; step RED->GREEN; request BRIGHT=64
    pwm_ticks("pwm_p0_dark", 0, 255, 0, 3'b010, 0, 2, 0, 8'd64, lows);
    check_int("pwm_p0_low_count", lows, 0);
    // P1: GREEN at 64/256; request BRIGHT=0
    pwm_ticks("pwm_p1_b64", 0, 255, 64, 3'b010, 2, 0, 0, 8'd0, lows);
    check_int("pwm_p1_low_count", lows, 64);
    // P2: BRIGHT=0 keeps green off; request 128
    pwm_ticks("pwm_p2_b0", 0, 255, 0, 3'b010, 2, 0, 0, 8'd128, lows);
    check_int("pwm_p2_low_count", lows, 0);
    // P3: 128 in force; change to 32 at pwm_cnt=10 must not affect this period
    pwm_ticks("pwm_p3_b128", 0, 255, 128, 3'b010, 2, 0, 10, 8'd32, lows);
    check_int("pwm_p3_low_count", lows, 128);
    // P4: the new 32 applies; request 0
    pwm_ticks("pwm_p4_b32", 0, 255, 32, 3'b010, 2, 0, 0, 8'd0, lows);
    check_int("pwm_p4_low_count", lows, 32);
    // P5: dark period, step GREEN->MAGENTA, request 255
    pwm_ticks("pwm_p5_steps", 0, 255, 0, 3'b101, 2, 3, 3, 8'd255, lows);
    check_int("pwm_p5_low_count", lows, 0);
    // P6: MAGENTA at 255/256: R and B lit, G always off
    pwm_ticks("pwm_p6_magenta", 0, 255, 255, 3'b101, 5, 0, 0, 8'd255, lows);
    check_int("pwm_p6_low_count", lows, 255);

    check_int("scoreboard_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
